// File: rtl/parking_slot_detect.sv
// rtl/parking_slot_detect.sv - Parking slot occupancy detector from ultrasonic echo counts
// Median-of-3 filtered distance feeds a hysteretic EMPTY/OCCUPIED FSM with a sensor-timeout FAULT state.
module parking_slot_detect #(
   parameter logic [19:0] NEAR_TH     = 20'd145_800,
   parameter logic [19:0] FAR_TH      = 20'd233_200,
   parameter logic [19:0] MIN_VALID   = 20'd2_900,
   parameter logic [2:0]  CONFIRM_N   = 3'd4,
   parameter logic [25:0] TIMEOUT_MAX = 26'd24_999_999
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        meas_valid,
   input  logic [19:0] meas_data,
   output logic [19:0] dist_filt,
   output logic        occupied,
   output logic        car_in,
   output logic        car_out,
   output logic        fault
);

   typedef enum logic [1:0] {
      S_EMPTY    = 2'd0,
      S_OCCUPIED = 2'd1,
      S_FAULT    = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [1:0]  fill_q, fill_d;
   logic [19:0] win0_q, win1_q;
   logic [19:0] filt_q, filt_d;
   logic        filt_valid_q, filt_valid_d;
   logic [25:0] tmo_q, tmo_d;
   logic        occ_q, occ_d;
   logic        car_in_q, car_in_d;
   logic        car_out_q, car_out_d;
   logic        accept;
   logic        timed_out;
   logic [19:0] med;
   logic [2:0]  cnt_inc;

   function automatic logic [19:0] median3(input logic [19:0] a, input logic [19:0] b,
                                           input logic [19:0] c);
      logic [19:0] lo;
      logic [19:0] hi;
      lo = (a < b) ? a : b;
      hi = (a < b) ? b : a;
      if (c < lo)      return lo;
      else if (c > hi) return hi;
      else             return c;
   endfunction

   // The incoming sample is the third window entry, so only two history registers are kept.
   assign accept    = meas_valid && (meas_data >= MIN_VALID) && (meas_data != 20'hFFFFF);
   assign timed_out = (tmo_q == TIMEOUT_MAX) && !accept && (state_q != S_FAULT);
   assign med       = median3(meas_data, win0_q, win1_q);
   assign cnt_inc   = cnt_q + 3'd1;

   always_comb begin
      fill_d       = fill_q;
      filt_d       = filt_q;
      filt_valid_d = 1'b0;
      tmo_d        = tmo_q;
      if (accept) begin
         tmo_d  = '0;
         fill_d = (fill_q == 2'd3) ? 2'd3 : fill_q + 2'd1;
         if (fill_q >= 2'd2) begin
            filt_d       = med;
            filt_valid_d = 1'b1;
         end
      end else if (tmo_q != TIMEOUT_MAX) begin
         tmo_d = tmo_q + 26'd1;
      end
      if (timed_out) fill_d = 2'd0;
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         win0_q       <= '0;
         win1_q       <= '0;
         fill_q       <= '0;
         filt_q       <= '0;
         filt_valid_q <= 1'b0;
         tmo_q        <= '0;
      end else begin
         if (accept) begin
            win1_q <= win0_q;
            win0_q <= meas_data;
         end
         fill_q       <= fill_d;
         filt_q       <= filt_d;
         filt_valid_q <= filt_valid_d;
         tmo_q        <= tmo_d;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q   <= S_EMPTY;
         cnt_q     <= '0;
         occ_q     <= 1'b0;
         car_in_q  <= 1'b0;
         car_out_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         occ_q     <= occ_d;
         car_in_q  <= car_in_d;
         car_out_q <= car_out_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      occ_d     = occ_q;
      car_in_d  = 1'b0;
      car_out_d = 1'b0;
      if (timed_out) begin
         state_d = S_FAULT;
         cnt_d   = '0;
      end else if (filt_valid_q) begin
         case (state_q)
            S_EMPTY: begin
               if (filt_q < NEAR_TH) begin
                  if (cnt_inc == CONFIRM_N) begin
                     state_d  = S_OCCUPIED;
                     cnt_d    = '0;
                     occ_d    = 1'b1;
                     car_in_d = 1'b1;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  cnt_d = '0;
               end
            end
            S_OCCUPIED: begin
               if (filt_q > FAR_TH) begin
                  if (cnt_inc == CONFIRM_N) begin
                     state_d   = S_EMPTY;
                     cnt_d     = '0;
                     occ_d     = 1'b0;
                     car_out_d = 1'b1;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  cnt_d = '0;
               end
            end
            default: begin
               // Recovery resumes the remembered occupancy; this median is not counted.
               state_d = occ_q ? S_OCCUPIED : S_EMPTY;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      dist_filt = filt_q;
      occupied  = occ_q;
      car_in    = car_in_q;
      car_out   = car_out_q;
      fault     = (state_q == S_FAULT);
   end

endmodule

// File: tb/tb_parking_slot_detect.sv
// tb/tb_parking_slot_detect.sv - Self-checking bench for parking_slot_detect
// Directed scenarios with hand-derived expectations plus a randomized run against a queue-based model.
module tb_parking_slot_detect;

   localparam logic [19:0] NEAR = 20'd145_800;
   localparam logic [19:0] FAR  = 20'd233_200;
   localparam logic [19:0] MINV = 20'd2_900;
   localparam int          CONF = 4;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        meas_valid = 1'b0;
   logic [19:0] meas_data = '0;
   logic [19:0] dist_filt;
   logic        occupied, car_in, car_out, fault;

   int n_checks = 0;
   int n_errors = 0;
   int n_in = 0;
   int n_out = 0;
   int n_bad = 0;

   logic [19:0] m_win[$];
   logic [19:0] exp_filt;
   logic        exp_occ, exp_in, exp_out, exp_fault;
   int          m_run, m_in_cnt, m_out_cnt;

   parking_slot_detect #(
      .NEAR_TH    (NEAR),
      .FAR_TH     (FAR),
      .MIN_VALID  (MINV),
      .CONFIRM_N  (3'd4),
      .TIMEOUT_MAX(26'd100)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .meas_valid(meas_valid),
      .meas_data (meas_data),
      .dist_filt (dist_filt),
      .occupied  (occupied),
      .car_in    (car_in),
      .car_out   (car_out),
      .fault     (fault)
   );

   always #5 sys_clk = ~sys_clk;

   always @(negedge sys_clk) begin
      if (car_in)  n_in++;
      if (car_out) n_out++;
      if ((car_in && car_out) || ((car_in || car_out) && fault)) n_bad++;
   end

   function automatic void model_reset();
      m_win.delete();
      exp_filt  = '0;
      exp_occ   = 1'b0;
      exp_in    = 1'b0;
      exp_out   = 1'b0;
      exp_fault = 1'b0;
      m_run     = 0;
   endfunction

   function automatic void model_timeout();
      m_win.delete();
      exp_fault = 1'b1;
      exp_in    = 1'b0;
      exp_out   = 1'b0;
      m_run     = 0;
   endfunction

   function automatic void model_sample(input logic [19:0] d);
      logic [19:0] a, b, c, t;
      exp_in  = 1'b0;
      exp_out = 1'b0;
      if (d < MINV || d == 20'hFFFFF) return;
      m_win.push_back(d);
      if (m_win.size() > 3) void'(m_win.pop_front());
      if (m_win.size() < 3) return;
      a = m_win[0]; b = m_win[1]; c = m_win[2];
      if (a > b) begin t = a; a = b; b = t; end
      if (b > c) begin t = b; b = c; c = t; end
      if (a > b) begin t = a; a = b; b = t; end
      exp_filt = b;
      if (exp_fault) begin
         exp_fault = 1'b0;
         m_run     = 0;
         return;
      end
      if ((!exp_occ && exp_filt < NEAR) || (exp_occ && exp_filt > FAR)) begin
         m_run++;
         if (m_run == CONF) begin
            m_run   = 0;
            exp_occ = !exp_occ;
            if (exp_occ) begin exp_in = 1'b1; m_in_cnt++; end
            else begin exp_out = 1'b1; m_out_cnt++; end
         end
      end else begin
         m_run = 0;
      end
   endfunction

   // Leaves the caller at the negedge of the cycle after the sample (N+1).
   task automatic pulse(input logic [19:0] d);
      @(negedge sys_clk);
      meas_valid = 1'b1;
      meas_data  = d;
      model_sample(d);
      @(negedge sys_clk);
      meas_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge sys_clk);
      sys_rst    = 1'b1;
      meas_valid = 1'b0;
      @(negedge sys_clk);
      sys_rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({dist_filt, occupied, car_in, car_out, fault} !== 24'd0) begin
         n_errors++;
         $display("FAIL reset_outputs: got filt=%0d occ=%b in=%b out=%b fault=%b required all 0",
                  dist_filt, occupied, car_in, car_out, fault);
      end
   endtask

   task automatic test_car_in();
      int b;
      do_reset();
      b = n_in;
      repeat (3) pulse(20'd300_000);
      for (int i = 1; i <= 5; i++) begin
         pulse(20'd100_000);
         @(negedge sys_clk);
         if (i == 4) begin
            n_checks++;
            if (n_in - b != 0) begin
               n_errors++;
               $display("FAIL car_in_early: got %0d pulses required 0", n_in - b);
            end
         end
         if (i == 5) begin
            n_checks++;
            if ({car_in, occupied, dist_filt} !== {1'b1, 1'b1, 20'd100_000}) begin
               n_errors++;
               $display("FAIL car_in_event: got in=%b occ=%b filt=%0d required 1 1 100000",
                        car_in, occupied, dist_filt);
            end
         end
      end
      @(negedge sys_clk);
      n_checks++;
      if (car_in !== 1'b0 || n_in - b != 1) begin
         n_errors++;
         $display("FAIL car_in_once: got in=%b pulses=%0d required 0 and 1", car_in, n_in - b);
      end
   endtask

   task automatic test_car_out();
      logic [19:0] seq [8];
      int bo, bi;
      seq = '{20'd300_000, 20'd300_000, 20'd180_000, 20'd300_000,
              20'd300_000, 20'd300_000, 20'd300_000, 20'd300_000};
      bo = n_out;
      bi = n_in;
      for (int i = 0; i < 8; i++) begin
         pulse(seq[i]);
         @(negedge sys_clk);
         if (i == 3) begin
            n_checks++;
            if (n_out - bo != 0 || occupied !== 1'b1) begin
               n_errors++;
               $display("FAIL car_out_early: got pulses=%0d occ=%b required 0 1", n_out - bo, occupied);
            end
         end
         if (i == 4) begin
            n_checks++;
            if ({car_out, occupied} !== 2'b10) begin
               n_errors++;
               $display("FAIL car_out_event: got out=%b occ=%b required 1 0", car_out, occupied);
            end
         end
      end
      n_checks++;
      if (n_out - bo != 1 || n_in != bi || occupied !== 1'b0 || dist_filt !== 20'd300_000) begin
         n_errors++;
         $display("FAIL car_out_final: got outs=%0d ins=%0d occ=%b filt=%0d required 1 0 0 300000",
                  n_out - bo, n_in - bi, occupied, dist_filt);
      end
   endtask

   task automatic test_hysteresis();
      logic [19:0] seq [10];
      int b;
      seq = '{20'd100_000, 20'd100_000, 20'd100_000, 20'd180_000, 20'd180_000,
              20'd100_000, 20'd100_000, 20'd100_000, 20'd100_000, 20'd100_000};
      do_reset();
      repeat (3) pulse(20'd300_000);
      b = n_in;
      for (int i = 0; i < 10; i++) begin
         pulse(seq[i]);
         if (i == 4) begin
            n_checks++;
            if (dist_filt !== 20'd180_000) begin
               n_errors++;
               $display("FAIL band_median: got %0d required 180000", dist_filt);
            end
         end
         @(negedge sys_clk);
         if (i == 8) begin
            n_checks++;
            if (n_in - b != 0) begin
               n_errors++;
               $display("FAIL band_clears_cnt: got %0d pulses required 0", n_in - b);
            end
         end
         if (i == 9) begin
            n_checks++;
            if ({car_in, occupied} !== 2'b11) begin
               n_errors++;
               $display("FAIL band_then_car_in: got in=%b occ=%b required 1 1", car_in, occupied);
            end
         end
      end
   endtask

   task automatic test_spike();
      int b;
      do_reset();
      b = n_in;
      repeat (3) pulse(20'd300_000);
      pulse(20'd50_000);
      n_checks++;
      if (dist_filt !== 20'd300_000) begin
         n_errors++;
         $display("FAIL spike_rejected: got %0d required 300000", dist_filt);
      end
      pulse(20'd300_000);
      for (int i = 1; i <= 4; i++) begin
         pulse(20'd100_000);
         @(negedge sys_clk);
         if (i == 3) begin
            n_checks++;
            if (n_in - b != 0) begin
               n_errors++;
               $display("FAIL spike_cnt: got %0d pulses required 0", n_in - b);
            end
         end
      end
      n_checks++;
      if (car_in !== 1'b1) begin
         n_errors++;
         $display("FAIL spike_then_car_in: got %b required 1", car_in);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      for (int c = 0; c <= 101; c++) begin
         if (c == 100) begin
            n_checks++;
            if (fault !== 1'b0) begin
               n_errors++;
               $display("FAIL timeout_early: fault=%b at cycle 100 required 0", fault);
            end
         end
         if (c == 101) begin
            n_checks++;
            if ({fault, occupied, car_in, car_out} !== 4'b1000) begin
               n_errors++;
               $display("FAIL timeout_fault: got fault=%b occ=%b in=%b out=%b required 1 0 0 0",
                        fault, occupied, car_in, car_out);
            end
         end
         meas_valid = 1'b1;
         meas_data  = c[0] ? 20'hFFFFF : 20'd0;
         @(negedge sys_clk);
      end
      meas_valid = 1'b0;
   endtask

   task automatic test_fault_recovery();
      int b;
      do_reset();
      repeat (3) pulse(20'd300_000);
      repeat (5) pulse(20'd100_000);
      for (int k = 1; k <= 102; k++) begin
         if (k == 101) begin
            n_checks++;
            if (fault !== 1'b0) begin
               n_errors++;
               $display("FAIL occ_timeout_early: fault=%b required 0", fault);
            end
         end
         if (k == 102) begin
            n_checks++;
            if ({fault, occupied} !== 2'b11) begin
               n_errors++;
               $display("FAIL occ_timeout_hold: got fault=%b occ=%b required 1 1", fault, occupied);
            end
         end
         meas_valid = 1'b1;
         meas_data  = 20'd0;
         @(negedge sys_clk);
      end
      meas_valid = 1'b0;
      model_timeout();
      b = n_in;
      for (int i = 1; i <= 3; i++) begin
         pulse(20'd100_000);
         @(negedge sys_clk);
         if (i == 2) begin
            n_checks++;
            if (fault !== 1'b1) begin
               n_errors++;
               $display("FAIL fault_refill: got fault=%b after 2 samples required 1", fault);
            end
         end
      end
      n_checks++;
      if ({fault, occupied, car_in, car_out, dist_filt} !== {4'b0100, 20'd100_000} || n_in != b) begin
         n_errors++;
         $display("FAIL fault_exit: got fault=%b occ=%b in=%b out=%b filt=%0d pulses=%0d required 0 1 0 0 100000 0",
                  fault, occupied, car_in, car_out, dist_filt, n_in - b);
      end
   endtask

   task automatic test_reset_mid();
      int b;
      do_reset();
      repeat (3) pulse(20'd300_000);
      repeat (4) pulse(20'd100_000);
      @(negedge sys_clk);
      b = n_in;
      sys_rst = 1'b1;
      @(negedge sys_clk);
      sys_rst = 1'b0;
      model_reset();
      n_checks++;
      if ({dist_filt, occupied, car_in, car_out, fault} !== 24'd0 || n_in != b) begin
         n_errors++;
         $display("FAIL mid_reset_outputs: got filt=%0d occ=%b in=%b out=%b fault=%b required all 0",
                  dist_filt, occupied, car_in, car_out, fault);
      end
      for (int i = 1; i <= 6; i++) begin
         pulse(20'd100_000);
         if (i == 2) begin
            n_checks++;
            if (dist_filt !== 20'd0) begin
               n_errors++;
               $display("FAIL mid_reset_refill: got filt=%0d required 0", dist_filt);
            end
         end
         @(negedge sys_clk);
         if (i == 5) begin
            n_checks++;
            if (n_in - b != 0) begin
               n_errors++;
               $display("FAIL mid_reset_history: got %0d pulses required 0", n_in - b);
            end
         end
      end
      n_checks++;
      if ({car_in, occupied} !== 2'b11) begin
         n_errors++;
         $display("FAIL mid_reset_car_in: got in=%b occ=%b required 1 1", car_in, occupied);
      end
   endtask

   task automatic test_back_to_back();
      logic [19:0] seq [8];
      int b;
      seq = '{20'd300_000, 20'd300_000, 20'd300_000, 20'd100_000,
              20'd100_000, 20'd100_000, 20'd100_000, 20'd100_000};
      do_reset();
      b = n_in;
      for (int i = 0; i < 8; i++) begin
         @(negedge sys_clk);
         meas_valid = 1'b1;
         meas_data  = seq[i];
         model_sample(seq[i]);
      end
      @(negedge sys_clk);
      meas_valid = 1'b0;
      repeat (4) @(negedge sys_clk);
      n_checks++;
      if (n_in - b != 1 || {occupied, car_in, dist_filt} !== {2'b10, 20'd100_000}) begin
         n_errors++;
         $display("FAIL back_to_back: got pulses=%0d occ=%b in=%b filt=%0d required 1 1 0 100000",
                  n_in - b, occupied, car_in, dist_filt);
      end
   endtask

   task automatic test_random();
      logic [19:0] edges [7];
      logic [19:0] d;
      int kind, run, bi, bo, mi, mo;
      edges = '{NEAR, NEAR - 20'd1, FAR, FAR + 20'd1, MINV, MINV - 20'd1, 20'hFFFFE};
      do_reset();
      bi = n_in; bo = n_out; mi = m_in_cnt; mo = m_out_cnt;
      run = 0; kind = 0;
      for (int i = 0; i < 80; i++) begin
         if (run == 0) begin
            kind = $urandom_range(0, 4);
            run  = $urandom_range(1, 6);
         end
         run--;
         case (kind)
            0:       d = 20'($urandom_range(2_900, 145_799));
            1:       d = 20'($urandom_range(233_201, 1_048_574));
            2:       d = 20'($urandom_range(145_800, 233_200));
            3:       d = ($urandom_range(0, 1) == 1) ? 20'hFFFFF : 20'($urandom_range(0, 2_899));
            default: d = edges[$urandom_range(0, 6)];
         endcase
         pulse(d);
         n_checks++;
         if (dist_filt !== exp_filt) begin
            n_errors++;
            $display("FAIL random_filt[%0d]: got %0d required %0d", i, dist_filt, exp_filt);
         end
         @(negedge sys_clk);
         n_checks++;
         if ({occupied, car_in, car_out, fault} !== {exp_occ, exp_in, exp_out, exp_fault}) begin
            n_errors++;
            $display("FAIL random_state[%0d]: got occ/in/out/fault=%b%b%b%b required %b%b%b%b",
                     i, occupied, car_in, car_out, fault, exp_occ, exp_in, exp_out, exp_fault);
         end
         repeat ($urandom_range(0, 3)) @(negedge sys_clk);
      end
      repeat (2) @(negedge sys_clk);
      n_checks++;
      if (n_in - bi != m_in_cnt - mi || n_out - bo != m_out_cnt - mo || n_bad != 0) begin
         n_errors++;
         $display("FAIL random_events: got in=%0d out=%0d illegal=%0d required in=%0d out=%0d illegal=0",
                  n_in - bi, n_out - bo, n_bad, m_in_cnt - mi, m_out_cnt - mo);
      end
   endtask

   initial begin
      m_in_cnt  = 0;
      m_out_cnt = 0;
      model_reset();
      test_reset();
      test_car_in();
      test_car_out();
      test_hysteresis();
      test_spike();
      test_timeout();
      test_fault_recovery();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200_000;
      $display("FAIL watchdog: run exceeded 200000 ns");
      $fatal(1, "watchdog expired");
   end

endmodule
